// File: rtl/fpu_mul_pkg.sv
// rtl/fpu_mul_pkg.sv - shared types and constants for the single-precision multiplier
package fpu_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  localparam int SP_MANT_W      = 24;
  localparam int SP_PROD_W      = 48;
  localparam int MUL_RADIX_BITS = 2;

endpackage

// File: rtl/fpu_mant_pp_gen.sv
// rtl/fpu_mant_pp_gen.sv - combinational partial product mcand*digit from shift/add terms
module fpu_mant_pp_gen #(
  parameter int P_W        = 48,
  parameter int RADIX_BITS = 2
) (
  input  logic [P_W-1:0]        mcand,
  input  logic [RADIX_BITS-1:0] digit,
  output logic [P_W-1:0]        pp
);

  // Sum one shifted copy of the multiplicand per set digit bit; no '*' so no DSP inference.
  always_comb begin
    pp = '0;
    for (int i = 0; i < RADIX_BITS; i++) begin
      if (digit[i]) begin
        pp = pp + (mcand << i);
      end
    end
  end

endmodule

// File: rtl/fpu_mant_mul_seq.sv
// rtl/fpu_mant_mul_seq.sv - iterative radix-2^RADIX_BITS mantissa multiplier (option: FPU_MANT_MUL_EARLY_TERM_EN)
module fpu_mant_mul_seq
  import fpu_mul_pkg::*;
#(
  parameter int WIDTH      = SP_MANT_W,
  parameter int RADIX_BITS = MUL_RADIX_BITS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_ready,
  input  logic [WIDTH-1:0]   a_m,
  input  logic [WIDTH-1:0]   b_m,
  output logic [2*WIDTH-1:0] product_out,
  output logic               out_ready,
  output logic               busy
);

  localparam int N_STEPS = WIDTH / RADIX_BITS;
  localparam int CNT_W   = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;

  generate
    if (WIDTH % RADIX_BITS != 0) begin : g_bad_radix
      $error("fpu_mant_mul_seq: WIDTH must be a multiple of RADIX_BITS");
    end
  endgenerate

  mul_state_e           state;
  mul_state_e           state_next;
  logic [2*WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   pp;
  logic [2*WIDTH-1:0]   acc_next;
  logic [WIDTH-1:0]     mplier;
  logic [WIDTH-1:0]     mplier_next;
  logic [CNT_W-1:0]     cnt;
  logic                 last_step;

  fpu_mant_pp_gen #(
    .P_W        (2*WIDTH),
    .RADIX_BITS (RADIX_BITS)
  ) u_pp_gen (
    .mcand (mcand),
    .digit (mplier[RADIX_BITS-1:0]),
    .pp    (pp)
  );

  assign acc_next    = acc + pp;
  assign mplier_next = mplier >> RADIX_BITS;

`ifdef FPU_MANT_MUL_EARLY_TERM_EN
  // Finish as soon as no multiplier bits remain; the accumulator is already final.
  assign last_step = (cnt == CNT_W'(N_STEPS-1)) || (mplier_next == '0);
`else
  assign last_step = (cnt == CNT_W'(N_STEPS-1));
`endif

  // Next-state and busy decode; dropping in_ready mid-calculation aborts to IDLE.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (in_ready) state_next = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (!in_ready)      state_next = IDLE;
        else if (last_step) state_next = DONE;
      end
      DONE: begin
        if (!in_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Datapath: latch operands on request, shift-add per step, publish the product on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand       <= '0;
      mplier      <= '0;
      acc         <= '0;
      cnt         <= '0;
      product_out <= '0;
      out_ready   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          out_ready <= 1'b0;
          if (in_ready) begin
            mcand  <= {{WIDTH{1'b0}}, a_m};
            mplier <= b_m;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        CALC: begin
          if (in_ready) begin
            acc    <= acc_next;
            mcand  <= mcand << RADIX_BITS;
            mplier <= mplier_next;
            cnt    <= cnt + CNT_W'(1);
            if (last_step) begin
              product_out <= acc_next;
              out_ready   <= 1'b1;
            end
          end
        end
        DONE: begin
          if (!in_ready) out_ready <= 1'b0;
        end
        default: out_ready <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_mant_mul_seq.sv
// tb/tb_fpu_mant_mul_seq.sv - randomized self-checking bench for fpu_mant_mul_seq
module tb_fpu_mant_mul_seq;

  localparam int W = 24;
  localparam int R = 2;
  localparam int N = W / R;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_ready = 1'b0;
  logic [W-1:0]   a_m = '0;
  logic [W-1:0]   b_m = '0;
  logic [2*W-1:0] product_out;
  logic           out_ready;
  logic           busy;

  int errors = 0;
  int checks = 0;
  logic [2*W-1:0] last_prod = '0;

  always #5 clk = ~clk;

  fpu_mant_mul_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_ready    (in_ready),
    .a_m         (a_m),
    .b_m         (b_m),
    .product_out (product_out),
    .out_ready   (out_ready),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Edges from request sample to out_ready, counting the sampling edge.
  function automatic int exp_edges(input logic [W-1:0] b);
    int k;
`ifdef FPU_MANT_MUL_EARLY_TERM_EN
    k = 1;
    while (k < N && (b >> (R*k)) != 0) k++;
`else
    k = N;
`endif
    return k + 1;
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold, input string tag);
    int edges;
    int busy_cyc;
    logic [2*W-1:0] exp;
    edges    = 0;
    busy_cyc = 0;
    exp      = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    @(negedge clk);
    a_m = a;
    b_m = b;
    in_ready = 1'b1;
    do begin
      @(posedge clk);
      #1;
      edges++;
      if (busy) busy_cyc++;
      if (edges == 1) begin
        a_m = W'($urandom);
        b_m = W'($urandom);
      end
    end while (!out_ready && edges < 40);
    check({tag, " latency"}, 64'(edges), 64'(exp_edges(b)));
    check({tag, " product"}, 64'(product_out), 64'(exp));
    check({tag, " busy_cycles"}, 64'(busy_cyc), 64'(exp_edges(b) - 1));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      a_m = W'($urandom);
      b_m = W'($urandom);
      @(posedge clk);
      #1;
      check({tag, " hold out_ready"}, 64'(out_ready), 64'd1);
      check({tag, " hold product"}, 64'(product_out), 64'(exp));
      check({tag, " hold busy"}, 64'(busy), 64'd0);
    end
    @(negedge clk);
    in_ready = 1'b0;
    @(posedge clk);
    #1;
    check({tag, " release out_ready"}, 64'(out_ready), 64'd0);
    check({tag, " release product"}, 64'(product_out), 64'(exp));
    last_prod = exp;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    repeat (2) @(negedge clk);
    check("reset out_ready", 64'(out_ready), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset product", 64'(product_out), 64'd0);
    rst_n = 1'b1;

    run_op(24'h800000, 24'h800000, 3, "half_sq");
    run_op(24'hFFFFFF, 24'hFFFFFF, 0, "max_sq");
    run_op(24'hC00000, 24'hA00000, 0, "c_x_a");
    run_op(24'h123456, 24'h000003, 0, "small_b");
    run_op(24'h7ABCDE, 24'h000000, 0, "zero_b");

    // Abort at CALC cycle 5: back to IDLE, no out_ready, product untouched.
    @(negedge clk);
    a_m = 24'h654321;
    b_m = 24'hFEDCBA;
    in_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    in_ready = 1'b0;
    @(posedge clk);
    #1;
    check("abort busy", 64'(busy), 64'd0);
    check("abort out_ready", 64'(out_ready), 64'd0);
    check("abort product", 64'(product_out), 64'(last_prod));
    repeat (N + 2) begin
      @(posedge clk);
      #1;
      check("abort idle out_ready", 64'(out_ready), 64'd0);
    end
    run_op(24'hABCDEF, 24'h9876A5, 0, "after_abort");

    // Asynchronous reset in the middle of a calculation.
    @(negedge clk);
    a_m = 24'hFFFFFF;
    b_m = 24'hC3C3C3;
    in_ready = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset out_ready", 64'(out_ready), 64'd0);
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset product", 64'(product_out), 64'd0);
    in_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(24'hFFFFFF, 24'hC3C3C3, 0, "after_reset");

    // Back-to-back with a one-cycle in_ready gap.
    run_op(24'h800001, 24'hFFFFFE, 4, "b2b_first");
    run_op(24'h3FFFFF, 24'h400001, 0, "b2b_second");

    for (int n = 0; n < 2500; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if ((n % 4) == 0) rb = rb >> $urandom_range(W, 0);
      run_op(ra, rb, 0, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
